// File: rtl/instr_register_pkg.sv
// Shared types for the instruction-register controller: opcode/operand/address
// types, the stored instruction record, register depth and read-FSM states.
package instr_register_pkg;

    localparam int IR_DEPTH = 32;

    typedef enum logic [3:0] {
        ZERO  = 4'd0,
        PASSA = 4'd1,
        PASSB = 4'd2,
        ADD   = 4'd3,
        SUB   = 4'd4,
        MULT  = 4'd5,
        DIV   = 4'd6,
        MOD   = 4'd7
    } opcode_t;

    typedef logic signed [31:0] operand_t;
    typedef logic [4:0]         address_t;

    typedef struct packed {
        opcode_t  opc;
        operand_t op_a;
        operand_t op_b;
    } instruction_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        RESP  = 2'd2
    } ctrl_state_t;

endpackage

// File: rtl/instr_rr_arbiter.sv
// Two-way round-robin arbiter. The grant is combinational so a requester sees
// ready in the same cycle it raises valid; only the tie-break is registered.
module instr_rr_arbiter (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       enable,
    output logic [1:0] gnt
);

    // Requester that wins when both ask: 0 = requester 0, 1 = requester 1.
    logic prio;

    // Grant a sole requester directly; on a tie the favoured requester wins.
    always_comb begin
        gnt = 2'b00;
        if (enable) begin
            if (req == 2'b11) begin
                gnt = prio ? 2'b10 : 2'b01;
            end else begin
                gnt = req;
            end
        end
    end

    // After any grant, favour the requester that did not just win.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prio <= 1'b0;
        end else if (gnt[0]) begin
            prio <= 1'b1;
        end else if (gnt[1]) begin
            prio <= 1'b0;
        end
    end

endmodule

// File: rtl/instr_reg_ctrl.sv
// Controller that runs an external 32-entry instruction register as a FIFO.
// Two requesters write through a round-robin arbiter; a consumer pops through
// an IDLE/FETCH/RESP read FSM with a two-cycle accept-to-data latency.
// Optional build macro INSTR_REG_CTRL_STATS_EN adds saturating 16-bit
// wr_total/rd_total counters of accepted writes and pops.
module instr_reg_ctrl
    import instr_register_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic [1:0]   req_valid,
    input  instruction_t req0_instr,
    input  instruction_t req1_instr,
    output logic [1:0]   req_ready,
    input  logic         rd_req,
    output logic         rd_valid,
    output instruction_t rd_instr,
    output address_t     rd_addr,
    output logic         load_en,
    output address_t     write_pointer,
    output opcode_t      opcode,
    output operand_t     operand_a,
    output operand_t     operand_b,
    output address_t     read_pointer,
    input  instruction_t instruction_word,
    output logic [5:0]   count,
    output logic         full,
    output logic         empty
`ifdef INSTR_REG_CTRL_STATS_EN
    ,
    output logic [15:0]  wr_total,
    output logic [15:0]  rd_total
`endif
);

    address_t     wr_ptr;
    address_t     rd_ptr;
    ctrl_state_t  state;
    logic [1:0]   gnt;
    logic         arb_en;
    logic         wr_acc;
    logic         pop_acc;
    instruction_t wr_instr_p0;

    assign full  = (count == 6'(IR_DEPTH));
    assign empty = (count == 6'd0);

    // Holding reset keeps every requester stalled.
    assign arb_en = !full && !reset;

    instr_rr_arbiter u_arb (
        .clk    (clk),
        .reset  (reset),
        .req    (req_valid),
        .enable (arb_en),
        .gnt    (gnt)
    );

    assign req_ready    = gnt;
    assign wr_acc       = |(req_valid & gnt);
    assign wr_instr_p0  = gnt[1] ? req1_instr : req0_instr;
    assign pop_acc      = (state == IDLE) && rd_req && !empty;
    assign read_pointer = rd_ptr;

    // Stage p1: register the granted payload onto the instruction-register write port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            load_en       <= 1'b0;
            write_pointer <= '0;
            opcode        <= ZERO;
            operand_a     <= '0;
            operand_b     <= '0;
            wr_ptr        <= '0;
        end else begin
            load_en <= wr_acc;
            if (wr_acc) begin
                write_pointer <= wr_ptr;
                opcode        <= wr_instr_p0.opc;
                operand_a     <= wr_instr_p0.op_a;
                operand_b     <= wr_instr_p0.op_b;
                wr_ptr        <= wr_ptr + 5'd1;
            end
        end
    end

    // Occupancy moves at accept time so a write and a pop together cancel out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else begin
            count <= count + {5'd0, wr_acc} - {5'd0, pop_acc};
        end
    end

    // Read FSM: FETCH samples the combinational read data, RESP presents it for one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            rd_valid <= 1'b0;
            rd_instr <= '0;
            rd_addr  <= '0;
            rd_ptr   <= '0;
        end else begin
            rd_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop_acc) state <= FETCH;
                end
                FETCH: begin
                    rd_instr <= instruction_word;
                    rd_addr  <= rd_ptr;
                    rd_ptr   <= rd_ptr + 5'd1;
                    rd_valid <= 1'b1;
                    state    <= RESP;
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef INSTR_REG_CTRL_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Lifetime transfer counters, pinned at all-ones once they get there.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_total <= '0;
            rd_total <= '0;
        end else begin
            if (wr_acc)  wr_total <= sat_inc(wr_total);
            if (pop_acc) rd_total <= sat_inc(rd_total);
        end
    end
`endif

endmodule

// File: tb/tb_instr_reg_ctrl.sv
// Bench for instr_reg_ctrl: a vector table for the basic write/pop and
// arbitration sequences, hand sequences for full/wrap, simultaneous
// write+pop and reset mid-read, then a random phase. A reference model of the
// FIFO and arbiter feeds write/read scoreboard queues checked every cycle.
module tb_instr_reg_ctrl;
    import instr_register_pkg::*;

    logic         clk = 1'b0;
    logic         reset;
    logic [1:0]   req_valid;
    instruction_t req0_instr, req1_instr;
    logic [1:0]   req_ready;
    logic         rd_req;
    logic         rd_valid;
    instruction_t rd_instr;
    address_t     rd_addr;
    logic         load_en;
    address_t     write_pointer;
    opcode_t      opcode;
    operand_t     operand_a, operand_b;
    address_t     read_pointer;
    instruction_t instruction_word;
    logic [5:0]   count;
    logic         full, empty;
`ifdef INSTR_REG_CTRL_STATS_EN
    logic [15:0]  wr_total, rd_total;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit rand_pay = 1'b0;

    always #5 clk = ~clk;

    instr_reg_ctrl dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid        (req_valid),
        .req0_instr       (req0_instr),
        .req1_instr       (req1_instr),
        .req_ready        (req_ready),
        .rd_req           (rd_req),
        .rd_valid         (rd_valid),
        .rd_instr         (rd_instr),
        .rd_addr          (rd_addr),
        .load_en          (load_en),
        .write_pointer    (write_pointer),
        .opcode           (opcode),
        .operand_a        (operand_a),
        .operand_b        (operand_b),
        .read_pointer     (read_pointer),
        .instruction_word (instruction_word),
        .count            (count),
        .full             (full),
        .empty            (empty)
`ifdef INSTR_REG_CTRL_STATS_EN
        ,
        .wr_total         (wr_total),
        .rd_total         (rd_total)
`endif
    );

    // Behavioural instruction register: synchronous write, combinational read.
    instruction_t mem [IR_DEPTH];
    initial for (int i = 0; i < IR_DEPTH; i++) mem[i] = '0;
    always @(posedge clk) if (load_en) mem[write_pointer] <= '{opcode, operand_a, operand_b};
    assign instruction_word = mem[read_pointer];

    task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model + scoreboards ----------------
    typedef struct { address_t addr; instruction_t ins; int due; } sb_t;
    sb_t wq[$];
    sb_t rq[$];
    sb_t mfifo[$];
    int       mcnt = 0;
    address_t mwp  = '0;
    bit       mprio = 1'b0;
    int       mstate = 0;
    int       m_wtot = 0, m_rtot = 0;

    always @(negedge clk) begin
        logic [1:0] egnt;
        bit wacc, racc;
        sb_t e;
        cyc++;
        if (reset) begin
            chk("rst_req_ready", req_ready, 2'b00);
            chk("rst_count", count, 0);
            chk("rst_load_en", load_en, 0);
            chk("rst_rd_valid", rd_valid, 0);
            chk("rst_write_pointer", write_pointer, 0);
            chk("rst_read_pointer", read_pointer, 0);
            chk("rst_rd_addr", rd_addr, 0);
            chk("rst_rd_instr", rd_instr, 0);
            chk("rst_opcode", opcode, 0);
            wq.delete(); rq.delete(); mfifo.delete();
            mcnt = 0; mwp = '0; mprio = 1'b0; mstate = 0; m_wtot = 0; m_rtot = 0;
        end else begin
            if (load_en) begin
                if (wq.size() == 0) chk("spurious_load_en", load_en, 0);
                else begin
                    e = wq.pop_front();
                    chk("wr_pointer", write_pointer, e.addr);
                    chk("wr_opcode", opcode, e.ins.opc);
                    chk("wr_operand_a", operand_a, e.ins.op_a);
                    chk("wr_operand_b", operand_b, e.ins.op_b);
                end
            end
            if (rd_valid) begin
                if (rq.size() == 0) chk("spurious_rd_valid", rd_valid, 0);
                else begin
                    e = rq.pop_front();
                    chk("rd_latency", cyc, e.due);
                    chk("rd_addr", rd_addr, e.addr);
                    chk("rd_instr", rd_instr, e.ins);
                end
            end else if (rq.size() > 0 && rq[0].due <= cyc) begin
                e = rq.pop_front();
                chk("rd_valid_timeout", rd_valid, 1);
            end
            chk("count", count, mcnt);
            chk("full", full, mcnt == IR_DEPTH);
            chk("empty", empty, mcnt == 0);
`ifdef INSTR_REG_CTRL_STATS_EN
            chk("wr_total", wr_total, m_wtot);
            chk("rd_total", rd_total, m_rtot);
`endif
            egnt = 2'b00;
            if (mcnt < IR_DEPTH) egnt = (req_valid == 2'b11) ? (mprio ? 2'b10 : 2'b01) : req_valid;
            chk("req_ready", req_ready, egnt);
            wacc = (egnt != 2'b00);
            racc = (mstate == 0) && rd_req && (mcnt > 0);
            if (wacc) begin
                e.addr = mwp;
                e.ins  = egnt[1] ? req1_instr : req0_instr;
                e.due  = 0;
                wq.push_back(e);
                mfifo.push_back(e);
                mwp = mwp + 5'd1;
                mprio = egnt[0];
                m_wtot++;
            end
            if (racc) begin
                e = mfifo.pop_front();
                e.due = cyc + 2;
                rq.push_back(e);
                m_rtot++;
            end
            mcnt = mcnt + int'(wacc) - int'(racc);
            mstate = racc ? 1 : (mstate == 1) ? 2 : 0;
        end
    end

    // ---------------- stimulus ----------------
    function automatic instruction_t rnd_instr();
        instruction_t r;
        r.opc  = opcode_t'($urandom_range(0, 7));
        r.op_a = operand_t'($urandom);
        r.op_b = operand_t'($urandom);
        return r;
    endfunction

    task automatic step(input logic [1:0] v, input bit r, input bit rs);
        @(posedge clk); #2;
        reset = rs; req_valid = v; rd_req = r;
        if (rand_pay) begin
            req0_instr = rnd_instr();
            req1_instr = rnd_instr();
        end
        @(negedge clk); #1;
    endtask

    typedef struct {
        bit rst; logic [1:0] vld; bit rd;
        logic [1:0] e_rdy; int e_cnt; bit e_ld; int e_wp; bit e_rdv; int e_raddr; instruction_t e_rins;
    } vec_t;

    function automatic vec_t mk(bit rs, logic [1:0] v, bit r, logic [1:0] rdy, int cnt,
                                bit ld, int wp, bit rdv, int ra, instruction_t ri);
        vec_t x;
        x.rst = rs; x.vld = v; x.rd = r; x.e_rdy = rdy; x.e_cnt = cnt;
        x.e_ld = ld; x.e_wp = wp; x.e_rdv = rdv; x.e_raddr = ra; x.e_rins = ri;
        return x;
    endfunction

    localparam int NV = 14;
    vec_t vec [NV];

    initial begin
        instruction_t i_add, none;
        i_add = '{ADD, 32'sd5, 32'sd3};
        none  = '0;
        // one write then three pops: only the first pop returns data
        vec[0]  = mk(1, 2'b00, 0, 2'b00, 0, 0, 0, 0, 0, none);
        vec[1]  = mk(0, 2'b01, 0, 2'b01, 0, 0, 0, 0, 0, none);
        vec[2]  = mk(0, 2'b00, 1, 2'b00, 1, 1, 0, 0, 0, none);
        vec[3]  = mk(0, 2'b00, 1, 2'b00, 0, 0, 0, 0, 0, none);
        vec[4]  = mk(0, 2'b00, 1, 2'b00, 0, 0, 0, 1, 0, i_add);
        vec[5]  = mk(0, 2'b00, 0, 2'b00, 0, 0, 0, 0, 0, none);
        vec[6]  = mk(0, 2'b00, 0, 2'b00, 0, 0, 0, 0, 0, none);
        // both requesters for four cycles: grants alternate starting at 0
        vec[7]  = mk(1, 2'b00, 0, 2'b00, 0, 0, 0, 0, 0, none);
        vec[8]  = mk(0, 2'b11, 0, 2'b01, 0, 0, 0, 0, 0, none);
        vec[9]  = mk(0, 2'b11, 0, 2'b10, 1, 1, 0, 0, 0, none);
        vec[10] = mk(0, 2'b11, 0, 2'b01, 2, 1, 1, 0, 0, none);
        vec[11] = mk(0, 2'b11, 0, 2'b10, 3, 1, 2, 0, 0, none);
        vec[12] = mk(0, 2'b00, 0, 2'b00, 4, 1, 3, 0, 0, none);
        vec[13] = mk(0, 2'b00, 0, 2'b00, 4, 0, 0, 0, 0, none);

        reset = 1'b1; req_valid = 2'b00; rd_req = 1'b0;
        req0_instr = i_add;
        req1_instr = '{SUB, -32'sd7, 32'sd9};

        for (int i = 0; i < NV; i++) begin
            step(vec[i].vld, vec[i].rd, vec[i].rst);
            chk($sformatf("v%0d_req_ready", i), req_ready, vec[i].e_rdy);
            chk($sformatf("v%0d_count", i), count, vec[i].e_cnt);
            chk($sformatf("v%0d_load_en", i), load_en, vec[i].e_ld);
            if (vec[i].e_ld) chk($sformatf("v%0d_write_pointer", i), write_pointer, vec[i].e_wp);
            chk($sformatf("v%0d_rd_valid", i), rd_valid, vec[i].e_rdv);
            if (vec[i].e_rdv) begin
                chk($sformatf("v%0d_rd_addr", i), rd_addr, vec[i].e_raddr);
                chk($sformatf("v%0d_rd_instr", i), rd_instr, vec[i].e_rins);
            end
        end

        rand_pay = 1'b1;

        // fill to full, pop one, write again after pointer wrap
        step(2'b00, 0, 1);
        for (int i = 0; i < 33; i++) step(2'b01, 0, 0);
        chk("full_count", count, 32);
        chk("full_flag", full, 1);
        chk("full_req_ready", req_ready, 2'b00);
        step(2'b00, 1, 0);
        step(2'b00, 0, 0);
        chk("after_pop_full", full, 0);
        chk("after_pop_count", count, 31);
        step(2'b01, 0, 0);
        step(2'b00, 0, 0);
        chk("wrap_load_en", load_en, 1);
        chk("wrap_write_pointer", write_pointer, 0);

        // simultaneous write and pop at count 5
        step(2'b00, 0, 1);
        for (int i = 0; i < 5; i++) step(2'b10, 0, 0);
        step(2'b01, 1, 0);
        chk("both_pre_count", count, 5);
        step(2'b00, 0, 0);
        chk("both_post_count", count, 5);
        for (int i = 0; i < 3; i++) step(2'b00, 0, 0);

        // reset during FETCH discards the in-flight pop
        step(2'b00, 0, 1);
        step(2'b01, 0, 0);
        step(2'b00, 1, 0);
        step(2'b00, 0, 1);
        for (int i = 0; i < 3; i++) begin
            step(2'b00, 0, 0);
            chk("rstfetch_rd_valid", rd_valid, 0);
            chk("rstfetch_count", count, 0);
            chk("rstfetch_empty", empty, 1);
`ifdef INSTR_REG_CTRL_STATS_EN
            chk("rstfetch_wr_total", wr_total, 0);
            chk("rstfetch_rd_total", rd_total, 0);
`endif
        end

        // random traffic against the model
        for (int i = 0; i < 400; i++) begin
            step(2'($urandom_range(0, 3)), ($urandom_range(0, 2) == 0), 0);
        end
        for (int i = 0; i < 6; i++) step(2'b00, 0, 0);
        chk("sb_drain", wq.size() + rq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
